// File: rtl/circle_gen.sv
// Midpoint circle rasteriser: outline or filled disc, clipped to the screen.
// Ports: start/mode/colour/centre/radius in, busy/done out, vga_* pixel stream.
module circle_gen #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [CW-1:0] colour,
    input  logic [XW-1:0] centre_x,
    input  logic [YW-1:0] centre_y,
    input  logic [XW-1:0] radius,
    input  logic          plot_ready,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);
    localparam int SW = XW + 2;
    typedef logic signed [SW-1:0] sc_t;
    localparam sc_t X_MAX = sc_t'(SCREEN_W - 1);
    localparam sc_t Y_MAX = sc_t'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, OUTLINE, SPAN, STEP, DONE
    } state_t;

    state_t        state, state_n;
    logic          mode_r;
    logic [CW-1:0] colour_r;
    sc_t           cx, cy, rad;
    sc_t           offx, offy, d;
    sc_t           sx;
    logic [2:0]    idx;
    logic          span_act;

    logic adv;
    sc_t  cand_x, cand_y;
    logic on_cand;
    sc_t  span_y, half, lo_raw, hi_raw;
    sc_t  span_lo, span_hi, cur_x;
    logic span_ok, span_end;
    sc_t  offy_s, offx_s, d_s;

    always_comb begin
        state_n  = state;
        busy     = 1'b0;
        done     = 1'b0;
        // A registered pixel that is still waiting freezes the datapath.
        adv      = !(vga_plot && !plot_ready);
        cand_x   = cx;
        cand_y   = cy;
        span_y   = cy;
        half     = offx;

        unique case (idx)
            3'd0: begin cand_x = cx + offx; cand_y = cy + offy; end
            3'd1: begin cand_x = cx + offy; cand_y = cy + offx; end
            3'd2: begin cand_x = cx - offy; cand_y = cy + offx; end
            3'd3: begin cand_x = cx - offx; cand_y = cy + offy; end
            3'd4: begin cand_x = cx - offx; cand_y = cy - offy; end
            3'd5: begin cand_x = cx - offy; cand_y = cy - offx; end
            3'd6: begin cand_x = cx + offy; cand_y = cy - offx; end
            3'd7: begin cand_x = cx + offx; cand_y = cy - offy; end
        endcase

        unique case (idx[1:0])
            2'd0: begin span_y = cy + offy; half = offx; end
            2'd1: begin span_y = cy - offy; half = offx; end
            2'd2: begin span_y = cy + offx; half = offy; end
            2'd3: begin span_y = cy - offx; half = offy; end
        endcase

        on_cand = !cand_x[SW-1] && (cand_x <= X_MAX) &&
                  !cand_y[SW-1] && (cand_y <= Y_MAX);

        lo_raw   = cx - half;
        hi_raw   = cx + half;
        span_lo  = lo_raw[SW-1] ? sc_t'(0) : lo_raw;
        span_hi  = (hi_raw > X_MAX) ? X_MAX : hi_raw;
        cur_x    = span_act ? sx : span_lo;
        span_ok  = !span_y[SW-1] && (span_y <= Y_MAX) &&
                   (span_lo <= span_hi);
        span_end = !span_ok || (cur_x >= span_hi);

        offy_s = offy + sc_t'(1);
        if (d[SW-1] || d == sc_t'(0)) begin
            offx_s = offx;
            d_s    = d + offy_s + offy_s + sc_t'(1);
        end else begin
            offx_s = offx - sc_t'(1);
            d_s    = d + ((offy_s - offx_s) <<< 1) + sc_t'(1);
        end

        unique case (state)
            IDLE: if (start) state_n = LOAD;
            LOAD: begin
                busy    = 1'b1;
                state_n = mode_r ? SPAN : OUTLINE;
            end
            OUTLINE: begin
                busy = 1'b1;
                if (adv && idx == 3'd7) state_n = STEP;
            end
            SPAN: begin
                busy = 1'b1;
                if (adv && span_end && idx[1:0] == 2'd3)
                    state_n = STEP;
            end
            STEP: begin
                busy = 1'b1;
                if (adv) begin
                    if (offy_s <= offx_s)
                        state_n = mode_r ? SPAN : OUTLINE;
                    else
                        state_n = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_r     <= 1'b0;
            colour_r   <= '0;
            cx         <= '0;
            cy         <= '0;
            rad        <= '0;
            offx       <= '0;
            offy       <= '0;
            d          <= '0;
            sx         <= '0;
            idx        <= '0;
            span_act   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: if (start) begin
                    mode_r   <= mode;
                    colour_r <= colour;
                    cx       <= sc_t'({2'b00, centre_x});
                    cy       <= sc_t'({{(SW-YW){1'b0}}, centre_y});
                    rad      <= sc_t'({2'b00, radius});
                end
                LOAD: begin
                    offx     <= rad;
                    offy     <= '0;
                    d        <= sc_t'(1) - rad;
                    idx      <= '0;
                    span_act <= 1'b0;
                end
                OUTLINE: if (adv) begin
                    vga_x      <= cand_x[XW-1:0];
                    vga_y      <= cand_y[YW-1:0];
                    vga_colour <= colour_r;
                    vga_plot   <= on_cand;
                    idx        <= idx + 3'd1;
                end
                SPAN: if (adv) begin
                    vga_x      <= cur_x[XW-1:0];
                    vga_y      <= span_y[YW-1:0];
                    vga_colour <= colour_r;
                    vga_plot   <= span_ok;
                    if (span_end) begin
                        span_act <= 1'b0;
                        idx      <= idx + 3'd1;
                    end else begin
                        span_act <= 1'b1;
                        sx       <= cur_x + sc_t'(1);
                    end
                end
                STEP: if (adv) begin
                    vga_plot <= 1'b0;
                    offx     <= offx_s;
                    offy     <= offy_s;
                    d        <= d_s;
                    idx      <= '0;
                    span_act <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
